// File: rtl/csa_pkg.sv
// Shared sizing helpers for carry-save adder trees.
package csa_pkg;

    localparam int CSA_DEFAULT_WIDTH = 6;

    // Width of a fully resolved a+b+c total: two bits wider than an operand.
    function automatic int csa_sum_width(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: the per-bit 3:2 compressor used by carry_save_adder.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic cy
);

    assign s  = x ^ y ^ z;
    assign cy = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/carry_save_adder.sv
// Registered 3:2 carry-save adder with a resolved-total convenience output.
module carry_save_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic               out_valid,
    output logic [WIDTH-1:0]   s,
    output logic [WIDTH:0]     c_out,
    output logic [WIDTH+1:0]   sum
);

    localparam int SUM_W = csa_sum_width(WIDTH);

    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] maj;
    logic [WIDTH:0]   c_out_next;
    logic [SUM_W-1:0] sum_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_fa (
            .x  (a[i]),
            .y  (b[i]),
            .z  (c[i]),
            .s  (s_next[i]),
            .cy (maj[i])
        );
    end

    // Carries carry weight 2^(i+1), so the vector is pre-shifted here.
    assign c_out_next = {maj, 1'b0};
    assign sum_next   = SUM_W'(c_out_next) + SUM_W'(s_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= '0;
            sum       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s     <= s_next;
                c_out <= c_out_next;
                sum   <= sum_next;
            end
        end
    end

endmodule

// File: tb/tb_carry_save_adder.sv
// Scoreboard bench for carry_save_adder at the default 6-bit width.
module tb_carry_save_adder;

    localparam int W = 6;

    typedef struct packed {
        logic         full;
        logic [W-1:0] s;
        logic [W:0]   c_out;
        logic [W+1:0] sum;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [W-1:0]   c = '0;
    logic           out_valid;
    logic [W-1:0]   s;
    logic [W:0]     c_out;
    logic [W+1:0]   sum;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    carry_save_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .s         (s),
        .c_out     (c_out),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vc,
                         input logic full, input logic [W-1:0] es, input logic [W:0] ec,
                         input logic [W+1:0] esum);
        exp_t e;
        @(posedge clk);
        #1;
        a = va; b = vb; c = vc; in_valid = 1'b1;
        e.full = full; e.s = es; e.c_out = ec; e.sum = esum;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 16'(exp_q.size()), 16'd0);
        exp_q.delete();
    endtask

    // Monitor: pops one expectation per presented result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 16'd1, 16'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 16'(sum), 16'(e.sum));
                    check("c_plus_s", 16'(c_out) + 16'(s), 16'(e.sum));
                    check("c_out_lsb", 16'(c_out[0]), 16'd0);
                    if (e.full) begin
                        check("s", 16'(s), 16'(e.s));
                        check("c_out", 16'(c_out), 16'(e.c_out));
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb, rc;

        // Reset held with live inputs.
        rst_n = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            @(negedge clk);
            check("rst_valid", 16'(out_valid), 16'd0);
            check("rst_s", 16'(s), 16'd0);
            check("rst_c_out", 16'(c_out), 16'd0);
            check("rst_sum", 16'(sum), 16'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;

        issue(6'd40, 6'd25, 6'd20, 1'b1, 6'd37, 7'd48, 8'd85);
        issue(6'd0, 6'd0, 6'd0, 1'b1, 6'd0, 7'd0, 8'd0);
        issue(6'd63, 6'd63, 6'd63, 1'b1, 6'd63, 7'd126, 8'd189);
        issue(6'd63, 6'd0, 6'd0, 1'b1, 6'd63, 7'd0, 8'd63);
        issue(6'd63, 6'd63, 6'd0, 1'b1, 6'd0, 7'd126, 8'd126);
        issue(6'd21, 6'd42, 6'd63, 1'b1, 6'd0, 7'd126, 8'd126);
        issue(6'd1, 6'd2, 6'd4, 1'b1, 6'd7, 7'd0, 8'd7);
        idle();
        drain();

        // out_valid drops, data holds at the last result.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 16'(out_valid), 16'd0);
            check("hold_s", 16'(s), 16'd7);
            check("hold_c_out", 16'(c_out), 16'd0);
            check("hold_sum", 16'(sum), 16'd7);
        end

        // Asynchronous reset between edges clears immediately.
        issue(6'd63, 6'd63, 6'd63, 1'b1, 6'd63, 7'd126, 8'd189);
        idle();
        drain();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_s", 16'(s), 16'd0);
        check("async_rst_c_out", 16'(c_out), 16'd0);
        check("async_rst_sum", 16'(sum), 16'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back random stream.
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
            issue(ra, rb, rc, 1'b0, '0, '0, 8'(ra) + 8'(rb) + 8'(rc));
        end
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
